// File: rtl/dff_readout_sequencer.sv
// Readout frame sequencer for the DFF error-count serializer:
// snapshot strobe, serializer sync, then a counted chain/bit shift window.
module dff_readout_sequencer #(
    parameter int unsigned NUM_CHAINS     = 20,
    parameter int unsigned BITS_PER_CHAIN = 12,
    parameter int unsigned SAVE_HOLD      = 2,
    parameter int unsigned PERIOD_W       = 24
) (
    input  logic                data_clk,
    input  logic                reset,
    input  logic                read_req,
    input  logic                abort,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] auto_period,
    output logic                save_data,
    output logic                ser_reset,
    output logic                frame_active,
    output logic                data_valid,
    output logic [4:0]          chain_idx,
    output logic [3:0]          bit_idx,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    localparam int unsigned CHAIN_W = 5;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned HOLD_W  = (SAVE_HOLD > 1) ? $clog2(SAVE_HOLD) : 1;

    localparam logic [CHAIN_W-1:0] LAST_CHAIN = CHAIN_W'(NUM_CHAINS - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(BITS_PER_CHAIN - 1);
    localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(SAVE_HOLD - 1);

    // Reject parameter sets the fixed index widths cannot represent
    if (NUM_CHAINS > 32) begin : g_bad_chains
        $error("dff_readout_sequencer: NUM_CHAINS must not exceed 32");
    end
    if (BITS_PER_CHAIN > 16) begin : g_bad_bits
        $error("dff_readout_sequencer: BITS_PER_CHAIN must not exceed 16");
    end
    if (SAVE_HOLD == 0) begin : g_bad_hold
        $error("dff_readout_sequencer: SAVE_HOLD must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_SYNC,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic [CHAIN_W-1:0]  chain_next;
    logic [BIT_W-1:0]    bit_next;
    logic                save_next;
    logic                ser_next;
    logic                active_next;
    logic                done_next;
    logic                overrun_next;

    logic [PERIOD_W-1:0] period_cnt;
    logic                auto_on_c;
    logic                auto_tick_c;
    logic                trigger_c;

    // Auto-trigger timer: free-runs 0..auto_period-1 only while enabled
    assign auto_on_c   = auto_en && (auto_period != '0);
    assign auto_tick_c = auto_on_c && (period_cnt >= (auto_period - PERIOD_W'(1)));
    assign trigger_c   = read_req | auto_tick_c;

    always_ff @(posedge data_clk) begin
        if (reset || !auto_on_c) begin
            period_cnt <= '0;
        end else if (auto_tick_c) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
        end
    end

    // State and registered outputs; reset overrides everything
    always_ff @(posedge data_clk) begin
        if (reset) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            chain_idx    <= '0;
            bit_idx      <= '0;
            save_data    <= 1'b0;
            ser_reset    <= 1'b0;
            frame_active <= 1'b0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            chain_idx    <= chain_next;
            bit_idx      <= bit_next;
            save_data    <= save_next;
            ser_reset    <= ser_next;
            frame_active <= active_next;
            data_valid   <= frame_active;
            busy         <= (state_next != S_IDLE);
            frame_done   <= done_next;
            overrun      <= overrun_next;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_next   = state;
        hold_next    = hold_cnt;
        chain_next   = chain_idx;
        bit_next     = bit_idx;
        save_next    = 1'b0;
        ser_next     = 1'b0;
        active_next  = 1'b0;
        done_next    = 1'b0;
        overrun_next = overrun;

        if (abort && (state != S_IDLE)) begin
            // Abort drops the frame and re-inits the serializer with one pulse
            state_next = S_IDLE;
            hold_next  = '0;
            chain_next = '0;
            bit_next   = '0;
            ser_next   = 1'b1;
        end else begin
            if (trigger_c && (state != S_IDLE)) begin
                overrun_next = 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (trigger_c && !abort) begin
                        state_next = S_SAVE;
                        hold_next  = '0;
                        save_next  = 1'b1;
                    end
                end
                S_SAVE: begin
                    if (hold_cnt == LAST_HOLD) begin
                        state_next = S_SYNC;
                        hold_next  = '0;
                        ser_next   = 1'b1;
                    end else begin
                        hold_next = HOLD_W'(hold_cnt + 1'b1);
                        save_next = 1'b1;
                    end
                end
                S_SYNC: begin
                    state_next  = S_SHIFT;
                    chain_next  = '0;
                    bit_next    = '0;
                    active_next = 1'b1;
                end
                S_SHIFT: begin
                    if ((chain_idx == LAST_CHAIN) && (bit_idx == LAST_BIT)) begin
                        state_next = S_DONE;
                        chain_next = '0;
                        bit_next   = '0;
                        done_next  = 1'b1;
                    end else if (bit_idx == LAST_BIT) begin
                        bit_next    = '0;
                        chain_next  = CHAIN_W'(chain_idx + 1'b1);
                        active_next = 1'b1;
                    end else begin
                        bit_next    = BIT_W'(bit_idx + 1'b1);
                        active_next = 1'b1;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_strobe_excl: assert property (@(posedge data_clk) disable iff (reset)
        !(save_data && ser_reset));
    a_active_busy: assert property (@(posedge data_clk) disable iff (reset)
        frame_active |-> busy);
    a_done_idle: assert property (@(posedge data_clk) disable iff (reset)
        frame_done |=> !busy);
`endif

endmodule

// File: tb/tb_dff_readout_sequencer.sv
// Scoreboard bench for dff_readout_sequencer: a frame-timeline reference model
// predicts every cycle's outputs; a monitor compares them on the falling edge.
module tb_dff_readout_sequencer;

    localparam int PERIOD_W = 24;
    localparam int SH       = 2;
    localparam int NC       = 20;
    localparam int BITS     = 12;
    localparam int NB       = NC * BITS;
    localparam int D        = SH + 2 + NB;

    typedef struct packed {
        logic       save;
        logic       ser;
        logic       active;
        logic       dv;
        logic [4:0] chain;
        logic [3:0] bidx;
        logic       busy;
        logic       done;
        logic       ovr;
    } obs_t;

    logic                data_clk;
    logic                reset;
    logic                read_req;
    logic                abort;
    logic                auto_en;
    logic [PERIOD_W-1:0] auto_period;
    logic                save_data;
    logic                ser_reset;
    logic                frame_active;
    logic                data_valid;
    logic [4:0]          chain_idx;
    logic [3:0]          bit_idx;
    logic                busy;
    logic                frame_done;
    logic                overrun;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dff_readout_sequencer dut (
        .data_clk    (data_clk),
        .reset       (reset),
        .read_req    (read_req),
        .abort       (abort),
        .auto_en     (auto_en),
        .auto_period (auto_period),
        .save_data   (save_data),
        .ser_reset   (ser_reset),
        .frame_active(frame_active),
        .data_valid  (data_valid),
        .chain_idx   (chain_idx),
        .bit_idx     (bit_idx),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    initial begin
        data_clk = 1'b0;
        forever #5 data_clk = ~data_clk;
    end

    // Reference model: a frame is a timeline of offsets from its trigger cycle
    initial begin : model
        int   cyc;
        int   t0;
        int   s;
        int   o;
        bit   ovr;
        bit   last_act;
        bit   on;
        bit   tick;
        bit   busy_c;
        bit   pulse;
        obs_t e;
        cyc = 0; t0 = -1; s = 0; ovr = 0; last_act = 0;
        forever begin
            @(posedge data_clk);
            on   = auto_en && (auto_period != 0);
            tick = 0;
            if (on) tick = (((cyc - s) % int'(auto_period)) == int'(auto_period) - 1);
            if (reset || !on) s = cyc + 1;
            busy_c = (t0 >= 0) && (cyc - t0 >= 1) && (cyc - t0 <= D);
            pulse  = 0;
            if (reset) begin
                t0 = -1;
                ovr = 0;
            end else if (busy_c && abort) begin
                t0 = -1;
                pulse = 1;
            end else if (busy_c && (read_req || tick)) begin
                ovr = 1;
            end else if (!busy_c && (read_req || tick) && !abort) begin
                t0 = cyc;
            end
            o = (t0 >= 0) ? (cyc + 1 - t0) : -1;
            e = '0;
            if (!reset) begin
                e.save   = (o >= 1) && (o <= SH);
                e.ser    = (o == SH + 1) || pulse;
                e.active = (o >= SH + 2) && (o <= SH + 1 + NB);
                if (e.active) begin
                    e.chain = 5'((o - SH - 2) / BITS);
                    e.bidx  = 4'((o - SH - 2) % BITS);
                end
                e.done = (o == D);
                e.busy = (o >= 1) && (o <= D);
                e.ovr  = ovr;
                e.dv   = last_act;
            end
            last_act = e.active;
            exp_q.push_back(e);
            cyc++;
        end
    end

    // Monitor: pops one prediction per cycle and compares away from the edge
    initial begin : monitor
        obs_t a;
        obs_t e;
        int   mcyc;
        mcyc = 0;
        forever begin
            @(negedge data_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.save = save_data;   a.ser = ser_reset;  a.active = frame_active;
                a.dv = data_valid;    a.chain = chain_idx; a.bidx = bit_idx;
                a.busy = busy;        a.done = frame_done; a.ovr = overrun;
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got save=%b ser=%b act=%b dv=%b chain=%0d bit=%0d busy=%b done=%b ovr=%b; expected save=%b ser=%b act=%b dv=%b chain=%0d bit=%0d busy=%b done=%b ovr=%b",
                             mcyc, a.save, a.ser, a.active, a.dv, a.chain, a.bidx, a.busy, a.done, a.ovr,
                             e.save, e.ser, e.active, e.dv, e.chain, e.bidx, e.busy, e.done, e.ovr);
                end
                mcyc++;
            end
        end
    end

    // Watchdog: the first frame must deliver frame_done within its scheduled window
    initial begin : done_watchdog
        int waited;
        bit seen;
        waited = 0;
        seen   = 0;
        @(posedge read_req);
        while (!seen && (waited < D + 20)) begin
            @(posedge data_clk);
            #1;
            waited++;
            if (frame_done === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout: frame_done not seen within %0d cycles of the first read_req", D + 20);
        end
    end

    task automatic cyc1();
        @(posedge data_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc1();
    endtask

    task automatic pulse_req();
        read_req = 1'b1;
        cyc1();
        read_req = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        cyc1();
        abort = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc1();
        reset = 1'b0;
    endtask

    initial begin : stimulus
        reset = 1'b1; read_req = 1'b0; abort = 1'b0; auto_en = 1'b0; auto_period = '0;
        idle(3);
        n_checks++;
        if ({save_data, ser_reset, frame_active, data_valid, chain_idx, bit_idx,
             busy, frame_done, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset state: save=%b ser=%b act=%b dv=%b chain=%0d bit=%0d busy=%b done=%b ovr=%b",
                     save_data, ser_reset, frame_active, data_valid, chain_idx, bit_idx,
                     busy, frame_done, overrun);
        end
        reset = 1'b0;

        // Basic frame, then a retrigger mid-SHIFT raising sticky overrun
        idle(6);
        pulse_req();
        idle(260);
        pulse_req();
        idle(103);
        pulse_req();
        idle(200);
        pulse_req();
        idle(250);

        // Abort mid-SHIFT, then a fresh full frame
        pulse_req();
        idle(SH + 1 + 50);
        pulse_abort();
        idle(5);
        pulse_req();
        idle(250);

        // Abort in SAVE, SYNC, on the last SHIFT bit, in DONE, and in IDLE with a request
        pulse_req();
        pulse_abort();
        idle(3);
        pulse_req();
        idle(SH);
        pulse_abort();
        idle(3);
        pulse_req();
        idle(SH + NB);
        pulse_abort();
        idle(3);
        pulse_req();
        idle(D - 1);
        pulse_abort();
        idle(3);
        read_req = 1'b1; abort = 1'b1;
        cyc1();
        read_req = 1'b0; abort = 1'b0;
        idle(5);

        // Auto trigger at 300 with a coincident host request, then 200 (overrun)
        pulse_reset();
        auto_period = PERIOD_W'(300);
        auto_en = 1'b1;
        idle(299);
        pulse_req();
        idle(950);
        auto_en = 1'b0;
        cyc1();
        auto_period = PERIOD_W'(200);
        auto_en = 1'b1;
        idle(1000);
        auto_en = 1'b0;
        idle(300);

        // Reset during SAVE and during SHIFT
        pulse_reset();
        pulse_req();
        pulse_reset();
        idle(3);
        pulse_req();
        idle(20);
        pulse_reset();
        idle(3);
        pulse_req();
        idle(250);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            read_req = ($urandom_range(0, 39) == 0);
            abort    = ($urandom_range(0, 199) == 0);
            reset    = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 299) == 0) begin
                if (auto_en) begin
                    auto_en = 1'b0;
                end else begin
                    auto_period = PERIOD_W'($urandom_range(0, 350));
                    auto_en = 1'b1;
                end
            end
            cyc1();
        end
        read_req = 1'b0; abort = 1'b0; reset = 1'b0; auto_en = 1'b0;
        idle(300);

        @(negedge data_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
